regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port (rw/writereg/data) between two sources:
//   - the pipeline WB stage;
//   - a multi-cycle execution unit (MC: mul/div/load-miss).
//  WB normally has priority. A starvation counter forces an MC grant and stalls WB.
//  Writes to r0 are suppressed here, so the register file never sees a write to r0.
//  Sits between WB/MC and the register file; drives its rw/writereg/data inputs.
// PARAMETERS
//  N           32  data width of register-file writes
//  AW          5   register address width
//  STARVE_MAX  4   consecutive cycles an MC request may lose to WB before a forced MC grant (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, synchronous, active-low
//  wb_valid     in   1   WB stage has a write this cycle
//  wb_reg       in   AW  WB destination register
//  wb_data      in   N   WB write data
//  wb_stall     out  1   WB not granted this cycle; pipeline holds WB inputs stable
//  mc_valid     in   1   MC unit has a write pending (held until accepted)
//  mc_reg       in   AW  MC destination register
//  mc_data      in   N   MC write data
//  mc_ready     out  1   MC write accepted this cycle (accepted when mc_valid & mc_ready)
//  rf_rw        out  1   register-file write enable (registered)
//  rf_writereg  out  AW  register-file write address (registered)
//  rf_data      out  N   register-file write data (registered)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - rf_rw=0, rf_writereg=0, rf_data=0, starve_cnt=0, state=NORMAL.
//    - While rst_n=0, mc_ready=0 and wb_stall=0 (combinational outputs).
//  - States:
//    - NORMAL: if wb_valid, grant WB; else if mc_valid, grant MC (mc_ready=1).
//    - FORCE: grant MC unconditionally; mc_ready=1; wb_stall=wb_valid. Lasts exactly one cycle.
//  - starve_cnt (width clog2(STARVE_MAX+1)), updated at posedge:
//    - +1 when mc_valid & wb_valid & state==NORMAL;
//    - cleared when MC is accepted or mc_valid=0.
//    - If the next value == STARVE_MAX, next state=FORCE; otherwise NORMAL.
//  - FORCE->NORMAL always, with starve_cnt=0.
//    - If mc_valid drops while in FORCE (protocol violation), no write is issued and state still returns to NORMAL.
//  - wb_stall=1 only in FORCE with wb_valid=1. In NORMAL, WB is never stalled.
//  - Latency: a grant in cycle t gives rf_rw=1 in cycle t+1, with rf_writereg/rf_data of the granted source.
//    - Back-to-back grants give rf_rw=1 on consecutive cycles.
//  - No grant, or granted reg==0: rf_rw=0 next cycle; rf_writereg/rf_data hold their previous values.
//    - A reg==0 request is still consumed (mc_ready=1 / no stall), but never written.
//  - Simultaneous WB+MC in NORMAL: WB wins, MC waits (mc_ready=0).
//  - Reset mid-FORCE: returns to NORMAL, the pending MC write is dropped, and MC must re-present it.
//  - Data is passed through unmodified; no arithmetic on the data path.
// STRUCTURE
//  - Shared package rf_arb_pkg:
//    - state encoding ST_NORMAL=1'b0, ST_FORCE=1'b1;
//    - REG_ZERO=5'd0;
//    - default widths N/AW.
//  - Sub-module rf_starve_ctr: saturating counter with inc/clr inputs and hit output (cnt_next==STARVE_MAX).
//  - Top level: FSM, grant mux, r0 filter, output register.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with wb_valid=1, mc_valid=1
//     -> rf_rw=0, mc_ready=0, wb_stall=0; after release, first grant goes to WB.
//  2. WB only: wb_valid=1, reg=5, data=0xDEADBEEF at t
//     -> rf_rw=1, rf_writereg=5, rf_data=0xDEADBEEF at t+1; rf_rw=0 at t+2.
//  3. MC only: mc_valid=1, reg=7, data=0x12
//     -> mc_ready=1 in the same cycle; rf write of r7=0x12 the next cycle.
//  4. Starvation: wb_valid=1 every cycle with distinct regs, plus mc_valid=1 reg=9
//     -> WB granted 4 cycles; 5th cycle FORCE: mc_ready=1, wb_stall=1;
//     -> r9 is written next; WB resumes the following cycle with its held data.
//  5. r0 filter: wb_valid=1 reg=0 data=0xFFFF
//     -> no stall, rf_rw=0 next cycle; then mc reg=0 -> mc_ready=1, rf_rw=0.
//  6. Reset while in FORCE: assert rst_n=0 in the FORCE cycle
//     -> no rf write next cycle; state NORMAL; starve_cnt=0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// FSM state encoding, the r0 address and default widths.
package rf_arb_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned N_DEF  = 32;
    localparam int unsigned AW_DEF = 5;

endpackage

// File: rtl/rf_starve_ctr.sv
// Saturating starvation counter; hit flags that the next count reaches STARVE_MAX.
module rf_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(STARVE_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign hit = (cnt_d == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between WB and the
// multi-cycle unit, with a starvation-forced MC grant and r0 write suppression.
module regfile_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned N          = N_DEF,
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_reg,
    input  logic [N-1:0]  wb_data,
    output logic          wb_stall,
    input  logic          mc_valid,
    input  logic [AW-1:0] mc_reg,
    input  logic [N-1:0]  mc_data,
    output logic          mc_ready,
    output logic          rf_rw,
    output logic [AW-1:0] rf_writereg,
    output logic [N-1:0]  rf_data
);

    state_e        state_q, state_d;
    logic          rf_rw_q, rf_rw_d;
    logic [AW-1:0] rf_writereg_q, rf_writereg_d;
    logic [N-1:0]  rf_data_q, rf_data_d;

    logic          grant_wb, grant_mc;
    logic          starve_inc, starve_clr, starve_hit;

    // Grant decision and handshake outputs; everything is quiet while in reset.
    always_comb begin
        grant_wb = 1'b0;
        grant_mc = 1'b0;
        mc_ready = 1'b0;
        wb_stall = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                ST_NORMAL: begin
                    if (wb_valid) begin
                        grant_wb = 1'b1;
                    end else if (mc_valid) begin
                        grant_mc = 1'b1;
                        mc_ready = 1'b1;
                    end
                end
                ST_FORCE: begin
                    mc_ready = 1'b1;
                    wb_stall = wb_valid;
                    grant_mc = mc_valid;
                end
                default: ;
            endcase
        end
    end

    assign starve_inc = (state_q == ST_NORMAL) && wb_valid && mc_valid;
    assign starve_clr = !mc_valid || mc_ready || (state_q == ST_FORCE);

    rf_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (starve_inc),
        .clr  (starve_clr),
        .hit  (starve_hit)
    );

    // FORCE lasts one cycle: the counter is cleared there, so hit cannot re-arm it.
    always_comb begin
        state_d = starve_hit ? ST_FORCE : ST_NORMAL;
    end

    always_comb begin
        rf_rw_d       = 1'b0;
        rf_writereg_d = rf_writereg_q;
        rf_data_d     = rf_data_q;
        if (grant_wb && (wb_reg != AW'(REG_ZERO))) begin
            rf_rw_d       = 1'b1;
            rf_writereg_d = wb_reg;
            rf_data_d     = wb_data;
        end else if (grant_mc && (mc_reg != AW'(REG_ZERO))) begin
            rf_rw_d       = 1'b1;
            rf_writereg_d = mc_reg;
            rf_data_d     = mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_NORMAL;
            rf_rw_q       <= 1'b0;
            rf_writereg_q <= '0;
            rf_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            rf_rw_q       <= rf_rw_d;
            rf_writereg_q <= rf_writereg_d;
            rf_data_q     <= rf_data_d;
        end
    end

    assign rf_rw       = rf_rw_q;
    assign rf_writereg = rf_writereg_q;
    assign rf_data     = rf_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_regfile_wr_arbiter;

    localparam int unsigned N          = 32;
    localparam int unsigned AW         = 5;
    localparam int unsigned STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_valid;
    logic [AW-1:0] wb_reg;
    logic [N-1:0]  wb_data;
    logic          wb_stall;
    logic          mc_valid;
    logic [AW-1:0] mc_reg;
    logic [N-1:0]  mc_data;
    logic          mc_ready;
    logic          rf_rw;
    logic [AW-1:0] rf_writereg;
    logic [N-1:0]  rf_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: MC losses in a row, pending forced grant, expected write port.
    int            m_losses = 0;
    bit            m_forced = 1'b0;
    bit            m_rw     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [N-1:0]  m_data   = '0;
    bit            m_ready  = 1'b0;
    bit            m_stall  = 1'b0;

    regfile_wr_arbiter #(
        .N         (N),
        .AW        (AW),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .wb_stall   (wb_stall),
        .mc_valid   (mc_valid),
        .mc_reg     (mc_reg),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .rf_rw      (rf_rw),
        .rf_writereg(rf_writereg),
        .rf_data    (rf_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Applies one cycle of inputs, checks the handshake outputs, then the registered write port.
    task automatic cyc(input string tag, input bit rst,
                       input bit wv, input logic [AW-1:0] wr, input logic [N-1:0] wd,
                       input bit mv, input logic [AW-1:0] mr, input logic [N-1:0] md);
        bit            wr_en;
        logic [AW-1:0] wr_a;
        logic [N-1:0]  wr_d;
        rst_n    = !rst;
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        mc_valid = mv; mc_reg = mr; mc_data = md;
        #1;
        wr_en = 1'b0; wr_a = '0; wr_d = '0;
        if (rst) begin
            m_ready = 1'b0; m_stall = 1'b0;
        end else if (m_forced) begin
            m_ready = 1'b1; m_stall = wv;
            if (mv) begin wr_en = 1'b1; wr_a = mr; wr_d = md; end
        end else begin
            m_stall = 1'b0;
            m_ready = !wv && mv;
            if (wv) begin wr_en = 1'b1; wr_a = wr; wr_d = wd; end
            else if (mv) begin wr_en = 1'b1; wr_a = mr; wr_d = md; end
        end
        check({tag, ".mc_ready"}, 64'(mc_ready), 64'(m_ready));
        check({tag, ".wb_stall"}, 64'(wb_stall), 64'(m_stall));
        if (rst) begin
            m_losses = 0; m_forced = 1'b0;
            m_rw = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            if (!m_forced && wv && mv) m_losses++;
            else m_losses = 0;
            m_forced = (m_losses == int'(STARVE_MAX));
            if (m_forced) m_losses = 0;
            m_rw = wr_en && (wr_a != 0);
            if (m_rw) begin m_addr = wr_a; m_data = wr_d; end
        end
        @(posedge clk);
        #1;
        check({tag, ".rf_rw"}, 64'(rf_rw), 64'(m_rw));
        check({tag, ".rf_writereg"}, 64'(rf_writereg), 64'(m_addr));
        check({tag, ".rf_data"}, 64'(rf_data), 64'(m_data));
    endtask

    bit            mc_pend;
    logic [AW-1:0] mc_r, wb_r;
    logic [N-1:0]  mc_d, wb_d;
    bit            wb_v, hold_wb, do_rst;

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
        @(posedge clk); #1;

        // Reset with both requesters active; first grant after release goes to WB.
        cyc("rst0", 1, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
        cyc("rst1", 1, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
        check("rst.rf_rw", 64'(rf_rw), 64'd0);
        cyc("rel", 0, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
        check("rel.wb_first", 64'(rf_writereg), 64'd3);
        cyc("rel.mc", 0, 0, 5'd0, 32'h0, 1, 5'd4, 32'hB);

        // WB only
        cyc("wb", 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
        check("wb.data", 64'(rf_data), 64'hDEADBEEF);
        cyc("wb.idle", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        check("wb.idle_hold", 64'(rf_data), 64'hDEADBEEF);

        // MC only
        cyc("mc", 0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h12);
        check("mc.reg", 64'(rf_writereg), 64'd7);

        // Starvation: four WB wins, then forced MC grant with WB stalled and held
        for (int unsigned i = 1; i <= 4; i++)
            cyc("starve", 0, 1, AW'(i), N'(i * 32'h100), 1, 5'd9, 32'h99);
        cyc("force", 0, 1, 5'd5, 32'h500, 1, 5'd9, 32'h99);
        check("force.stalled", 64'(wb_stall), 64'd0);
        check("force.r9", 64'(rf_writereg), 64'd9);
        cyc("resume", 0, 1, 5'd5, 32'h500, 0, 5'd0, 32'h0);
        check("resume.r5", 64'(rf_writereg), 64'd5);

        // r0 filter on both sources
        cyc("r0.wb", 0, 1, 5'd0, 32'hFFFF, 0, 5'd0, 32'h0);
        cyc("r0.mc", 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h77);

        // Reset in the FORCE cycle drops the MC write and clears starvation
        for (int unsigned i = 1; i <= 4; i++)
            cyc("pre_rst", 0, 1, AW'(i + 10), N'(i), 1, 5'd20, 32'h2020);
        cyc("force_rst", 1, 1, 5'd15, 32'h5, 1, 5'd20, 32'h2020);
        for (int unsigned i = 1; i <= 4; i++)
            cyc("post_rst", 0, 1, AW'(i + 20), N'(i), 1, 5'd20, 32'h2020);
        cyc("post_force", 0, 1, 5'd25, 32'h5, 1, 5'd20, 32'h2020);

        // Random traffic honouring the hold-until-accepted / hold-while-stalled protocol
        mc_pend = 1'b0; hold_wb = 1'b0;
        mc_r = '0; mc_d = '0; wb_r = '0; wb_d = '0; wb_v = 1'b0;
        for (int unsigned k = 0; k < 600; k++) begin
            if (!mc_pend && ($urandom_range(0, 2) == 0)) begin
                mc_pend = 1'b1;
                mc_r = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                mc_d = $urandom;
            end
            if (!hold_wb) begin
                wb_v = ($urandom_range(0, 3) != 0);
                wb_r = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                wb_d = $urandom;
            end
            do_rst = ($urandom_range(0, 99) == 0);
            cyc("rand", do_rst, wb_v, wb_r, wb_d, mc_pend, mc_r, mc_d);
            if (mc_pend && m_ready) mc_pend = 1'b0;
            hold_wb = m_stall;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
